// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared 640x480@60 timing constants, scan state enum and colour codes
// Purpose: one place for the horizontal/vertical line budget, the scanout FSM
//          state type and the 4-bit colour levels used by vga_timing and
//          vga_binary_scanout.
// Ports:   none (package).
package vga_pkg;

  // Horizontal budget in pixel ticks.
  localparam logic [9:0] H_VISIBLE    = 10'd640;
  localparam logic [9:0] H_FP         = 10'd16;
  localparam logic [9:0] H_SYNC       = 10'd96;
  localparam logic [9:0] H_BP         = 10'd48;
  localparam logic [9:0] H_SYNC_START = H_VISIBLE + H_FP;
  localparam logic [9:0] H_SYNC_END   = H_SYNC_START + H_SYNC;
  localparam logic [9:0] H_TOTAL      = H_SYNC_END + H_BP;

  // Vertical budget in lines.
  localparam logic [9:0] V_VISIBLE    = 10'd480;
  localparam logic [9:0] V_FP         = 10'd10;
  localparam logic [9:0] V_SYNC       = 10'd2;
  localparam logic [9:0] V_BP         = 10'd33;
  localparam logic [9:0] V_SYNC_START = V_VISIBLE + V_FP;
  localparam logic [9:0] V_SYNC_END   = V_SYNC_START + V_SYNC;
  localparam logic [9:0] V_TOTAL      = V_SYNC_END + V_BP;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } scan_state_e;

  localparam logic [3:0] COLOR_FULL = 4'hF;
  localparam logic [3:0] COLOR_NONE = 4'h0;

  // Half-open range test lo <= val < hi.
  function automatic logic in_span(input logic [9:0] val,
                                   input logic [9:0] lo,
                                   input logic [9:0] hi);
    return (val >= lo) && (val < hi);
  endfunction

endpackage

// File: rtl/vga_timing.sv
// rtl/vga_timing.sv - 25 MHz pixel tick, scan counters and raw sync/visible flags
// Purpose: divides the 50 MHz clock into a pixel tick and walks hcount/vcount
//          over the full 800x525 raster.
// Ports:
//   clk_i, rst_ni             clock, asynchronous active-low reset
//   tick_o                    high for the clock that ends each pixel period
//   hcount_o, vcount_o        current raster position
//   hcount_next_o/vcount_next_o  position the counters take after this clock
//   hsync_raw_o, vsync_raw_o  active-low syncs decoded from the current position
//   visible_o                 current position is inside 640x480
module vga_timing
  import vga_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_ni,
  output logic       tick_o,
  output logic [9:0] hcount_o,
  output logic [9:0] vcount_o,
  output logic [9:0] hcount_next_o,
  output logic [9:0] vcount_next_o,
  output logic       hsync_raw_o,
  output logic       vsync_raw_o,
  output logic       visible_o
);

  logic       tick_q;
  logic [9:0] hcount_q, hcount_d;
  logic [9:0] vcount_q, vcount_d;

  always_comb begin
    hcount_d = hcount_q;
    vcount_d = vcount_q;
    if (tick_q) begin
      if (hcount_q == H_TOTAL - 10'd1) begin
        hcount_d = 10'd0;
        vcount_d = (vcount_q == V_TOTAL - 10'd1) ? 10'd0 : vcount_q + 10'd1;
      end else begin
        hcount_d = hcount_q + 10'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tick_q   <= 1'b0;
      hcount_q <= 10'd0;
      vcount_q <= 10'd0;
    end else begin
      tick_q   <= ~tick_q;
      hcount_q <= hcount_d;
      vcount_q <= vcount_d;
    end
  end

  assign tick_o        = tick_q;
  assign hcount_o      = hcount_q;
  assign vcount_o      = vcount_q;
  assign hcount_next_o = hcount_d;
  assign vcount_next_o = vcount_d;
  assign hsync_raw_o   = ~in_span(hcount_q, H_SYNC_START, H_SYNC_END);
  assign vsync_raw_o   = ~in_span(vcount_q, V_SYNC_START, V_SYNC_END);
  assign visible_o     = (hcount_q < H_VISIBLE) && (vcount_q < V_VISIBLE);

endmodule

// File: rtl/vga_binary_scanout.sv
// rtl/vga_binary_scanout.sv - shows the 64x64 1-bit result RAM scaled and centred on 640x480 VGA
// Purpose: fetches result pixels, gates them with the done flag at frame
//          boundaries and drives registered sync and colour outputs.
//          Optional macro FRAME_BORDER_EN draws a green ring around the image.
// Ports:
//   clock_50MHz, reset_n   clock, asynchronous active-low reset
//   ACABOU                 coprocessor done level
//   q                      result RAM data, one clock after rdaddress
//   rdaddress              result RAM address {row[5:0], col[5:0]}
//   hsync, vsync           active-low syncs
//   vga_r, vga_g, vga_b    4-bit colour
module vga_binary_scanout
  import vga_pkg::*;
#(
  parameter int SCALE_SHIFT = 2,
  parameter int X_OFF       = 192,
  parameter int Y_OFF       = 112
) (
  input  logic        clock_50MHz,
  input  logic        reset_n,
  input  logic        ACABOU,
  input  logic        q,
  output logic [11:0] rdaddress,
  output logic        hsync,
  output logic        vsync,
  output logic [3:0]  vga_r,
  output logic [3:0]  vga_g,
  output logic [3:0]  vga_b
);

  localparam int         WIN  = 64 << SCALE_SHIFT;
  localparam logic [9:0] X_LO = 10'(X_OFF);
  localparam logic [9:0] X_HI = 10'(X_OFF + WIN);
  localparam logic [9:0] Y_LO = 10'(Y_OFF);
  localparam logic [9:0] Y_HI = 10'(Y_OFF + WIN);

  logic       tick;
  logic [9:0] h_cur, v_cur, h_nxt, v_nxt;
  logic       hsync_raw, vsync_raw, visible;

  vga_timing u_timing (
    .clk_i         (clock_50MHz),
    .rst_ni        (reset_n),
    .tick_o        (tick),
    .hcount_o      (h_cur),
    .vcount_o      (v_cur),
    .hcount_next_o (h_nxt),
    .vcount_next_o (v_nxt),
    .hsync_raw_o   (hsync_raw),
    .vsync_raw_o   (vsync_raw),
    .visible_o     (visible)
  );

  // The fetch looks at the position the counters are moving to, so q for
  // (h,v) is back by the time the counters sit at (h,v) and the outputs
  // for that pixel are registered at the following tick.
  logic        fetch_win;
  logic [5:0]  h_cell, v_cell;
  logic [11:0] rdaddress_d;

  assign fetch_win   = in_span(h_nxt, X_LO, X_HI) && in_span(v_nxt, Y_LO, Y_HI);
  assign h_cell      = 6'((h_nxt - X_LO) >> SCALE_SHIFT);
  assign v_cell      = 6'((v_nxt - Y_LO) >> SCALE_SHIFT);
  assign rdaddress_d = {v_cell, h_cell};

  // Frame boundary: the tick on which the counters wrap into (0,0).
  logic frame_start;
  assign frame_start = tick && (h_nxt == 10'd0) && (v_nxt == 10'd0);

  logic disp_win, ring;
  assign disp_win = in_span(h_cur, X_LO, X_HI) && in_span(v_cur, Y_LO, Y_HI);

`ifdef FRAME_BORDER_EN
  localparam logic [9:0] X_RING = 10'(X_OFF - 1);
  localparam logic [9:0] Y_RING = 10'(Y_OFF - 1);
  assign ring = in_span(h_cur, X_RING, X_HI + 10'd1) &&
                in_span(v_cur, Y_RING, Y_HI + 10'd1) &&
                ((h_cur == X_RING) || (h_cur == X_HI) ||
                 (v_cur == Y_RING) || (v_cur == Y_HI));
`else
  assign ring = 1'b0;
`endif

  scan_state_e state_q;
  logic        pix_white, pix_green;
  logic [3:0]  r_d, g_d, b_d;

  assign pix_white = (state_q == SHOW) && visible && disp_win && q;
  assign pix_green = pix_white || (visible && ring);
  assign r_d       = pix_white ? COLOR_FULL : COLOR_NONE;
  assign g_d       = pix_green ? COLOR_FULL : COLOR_NONE;
  assign b_d       = pix_white ? COLOR_FULL : COLOR_NONE;

  logic [11:0] rdaddress_q;
  logic        hsync_q, vsync_q;
  logic [3:0]  r_q, g_q, b_q;

  always_ff @(posedge clock_50MHz or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= BLANK;
      rdaddress_q <= 12'd0;
      hsync_q     <= 1'b1;
      vsync_q     <= 1'b1;
      r_q         <= COLOR_NONE;
      g_q         <= COLOR_NONE;
      b_q         <= COLOR_NONE;
    end else if (tick) begin
      if (fetch_win) begin
        rdaddress_q <= rdaddress_d;
      end
      hsync_q <= hsync_raw;
      vsync_q <= vsync_raw;
      r_q     <= r_d;
      g_q     <= g_d;
      b_q     <= b_d;
      // Done flag is sampled only here so a frame is never half shown.
      if (frame_start) begin
        case (state_q)
          BLANK:   if (ACABOU)  state_q <= SHOW;
          SHOW:    if (!ACABOU) state_q <= BLANK;
          default: state_q <= BLANK;
        endcase
      end
    end
  end

  assign rdaddress = rdaddress_q;
  assign hsync     = hsync_q;
  assign vsync     = vsync_q;
  assign vga_r     = r_q;
  assign vga_g     = g_q;
  assign vga_b     = b_q;

endmodule
